rom_load_arbiter: RTL
=====================

// Module: rom_load_arbiter
// PURPOSE
// Shares the single ROM-loader port among NUM_REQ loader masters (pattern loader, SPI/UART boot path).
// Grants whole load sessions round-robin and muxes one master's reset/load/data to the loader.
// Routes ack/load_received back to the granted master only; holds the Hack CPU in reset while any session runs.
// Sits between the loader masters and the ROM loader inside the SoC top.
// PARAMETERS
// NUM_REQ         2      number of loader masters (>=2)
// DATA_WIDTH      16     ROM word width
// TIMEOUT_CYCLES  65535  max cycles in ACTIVE without load_received before abort
// HOLD_CYCLES     4      extra cycles cpu_reset_hold stays high after a session ends
// PORTS
// clk                   in   1                   clock
// reset                 in   1                   reset, synchronous, active-high
// req                   in   NUM_REQ             session request, level, one bit per master
// done                  in   NUM_REQ             master reports its session complete (level or pulse)
// grant                 out  NUM_REQ             one-hot ownership; all zero when idle
// m_rom_loader_reset    in   NUM_REQ             per-master loader reset
// m_rom_loader_load     in   NUM_REQ             per-master load strobe
// m_rom_loader_data     in   NUM_REQ*DATA_WIDTH  per-master data, master i at [i*DATA_WIDTH +: DATA_WIDTH]
// m_rom_loader_ack      out  NUM_REQ             ack routed to granted master; 0 elsewhere
// m_load_received       out  NUM_REQ             load_received routed to granted master; 0 elsewhere
// rom_loader_reset      out  1                   to ROM loader
// rom_loader_load       out  1                   to ROM loader
// rom_loader_data       out  DATA_WIDTH          to ROM loader
// rom_loader_ack        in   1                   from ROM loader
// rom_loader_load_received in 1                  from ROM loader, one-cycle pulse per accepted word
// cpu_reset_hold        out  1                   keeps Hack CPU in reset
// busy                  out  1                   state != IDLE
// timeout               out  1                   sticky; set on abort, cleared on next grant
// BEHAVIOUR
// - Reset: state=IDLE, grant=0, rr_ptr=0, all rom_loader_* and m_* outputs 0, busy=0, timeout=0.
//   cpu_reset_hold=1 during reset and for HOLD_CYCLES cycles after reset deasserts.
// - All outputs registered. Mux selection uses the registered grant, so data path latency is 1 cycle.
// - FSM:
//   IDLE -> GRANT when any req. Winner = first set req at or after rr_ptr (wrapping). Same cycle: grant<=onehot(winner), timeout<=0.
//   GRANT: one cycle with all loader outputs forced 0 (settle) -> ACTIVE.
//   ACTIVE: forward granted master's reset/load/data; route ack/load_received to it.
//     ACTIVE -> RELEASE when done[g] or !req[g], or on timeout.
//     Timeout: idle counter resets on load_received or rom_loader_reset; when it reaches TIMEOUT_CYCLES-1 -> timeout<=1.
//   RELEASE: grant<=0; rom_loader_load and rom_loader_reset forced 0; rr_ptr<=g+1 mod NUM_REQ.
//     Hold counter starts at HOLD_CYCLES; -> IDLE when the counter hits 0 and rom_loader_ack=1.
// - cpu_reset_hold = 1 in GRANT/ACTIVE/RELEASE and while the post-reset hold counter is nonzero; 0 only in IDLE after the hold expires.
// - Simultaneous reqs: round-robin; a master that just finished has lowest priority next.
// - A req arriving during a session waits; it is never pre-empted.
// - load_received arriving in GRANT or RELEASE is dropped (not routed).
// - done and req drop in the same cycle: a single transition to RELEASE.
// - reset mid-session: immediate return to reset values; the loader sees load=0 on the next cycle.
// - Idle counter width: $clog2(TIMEOUT_CYCLES+1). Hold counter width: $clog2(HOLD_CYCLES+1). Both saturate, never wrap.
// STRUCTURE
// - Shared package hack_soc_pkg: localparams for the state encoding (IDLE, GRANT, ACTIVE, RELEASE).
//   Also ROM_DATA_WIDTH default.
// - One sub-module: rr_arbiter (NUM_REQ req + pointer -> one-hot grant, combinational).
// - Mux/demux, counters and FSM stay in this module.
// TESTING
// 1 Reset: hold reset 3 cycles -> grant=0, load=0, busy=0, cpu_reset_hold=1 for 4 cycles after release, then 0.
// 2 Single session: master1 req, 8 words each acked by a load_received pulse, then done.
//   -> grant=2'b10 one cycle after req; loader data matches master1 one cycle late; m_load_received[0] stays 0.
// 3 Contention: req=2'b11 from IDLE -> master0 first; after done, master1 granted.
//   Repeat -> master1 first (round-robin).
// 4 Timeout: TIMEOUT_CYCLES=16, master holds load with no load_received -> timeout=1 at cycle 16 of ACTIVE.
//   load forced 0, grant=0, returns to IDLE.
// 5 Mid-session reset: assert reset in ACTIVE with load=1 -> next cycle rom_loader_load=0, grant=0, state IDLE.
// 6 Req drop: master drops req mid-load without done -> RELEASE; IDLE only after rom_loader_ack=1 and 4 hold cycles.

Source files
------------

// File: rtl/hack_soc_pkg.sv
// Shared definitions for the Hack SoC blocks.
//   ROM_DATA_WIDTH : default ROM word width
//   STATE_*        : encoding of the ROM-load arbiter session FSM
//   arb_state_t    : typed view of that encoding
package hack_soc_pkg;

  localparam int ROM_DATA_WIDTH = 16;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_GRANT   = 2'd1;
  localparam logic [1:0] STATE_ACTIVE  = 2'd2;
  localparam logic [1:0] STATE_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = STATE_IDLE,
    ST_GRANT   = STATE_GRANT,
    ST_ACTIVE  = STATE_ACTIVE,
    ST_RELEASE = STATE_RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req   : request bits, one per master
//   ptr   : one-hot position of the highest-priority master
//   grant : one-hot winner (first set req at or after ptr, wrapping); zero if no req
//   valid : any request present
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick;

  // With a one-hot ptr, ~(ptr - 1) selects ptr's bit and every bit above it.
  assign upper_mask = ~(ptr - NUM_REQ'(1));
  assign masked     = req & upper_mask;
  // Nothing at or above ptr means the search wraps to the lowest request.
  assign pick       = (|masked) ? masked : req;
  // Keep only the lowest set bit of pick.
  assign grant      = pick & (~pick + NUM_REQ'(1));
  assign valid      = |req;

endmodule

// File: rtl/rom_load_arbiter.sv
// Shares the single ROM-loader port among NUM_REQ loader masters. Whole load
// sessions are granted round-robin; the granted master's reset/load/data are
// forwarded to the loader one cycle late, and ack/load_received go back to that
// master only. The Hack CPU is held in reset while any session runs.
//   clk, reset                 : clock, synchronous active-high reset
//   req, done                  : per-master session request / session complete
//   grant                      : one-hot session ownership, zero when idle
//   m_rom_loader_reset/load/data : per-master loader controls
//   m_rom_loader_ack, m_load_received : loader responses routed to the owner
//   rom_loader_reset/load/data : to the ROM loader
//   rom_loader_ack, rom_loader_load_received : from the ROM loader
//   cpu_reset_hold             : keeps the CPU in reset
//   busy                       : a session is in progress
//   timeout                    : sticky, last session aborted for inactivity
module rom_load_arbiter
  import hack_soc_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = ROM_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int HOLD_CYCLES    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            grant,
  input  logic [NUM_REQ-1:0]            m_rom_loader_reset,
  input  logic [NUM_REQ-1:0]            m_rom_loader_load,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] m_rom_loader_data,
  output logic [NUM_REQ-1:0]            m_rom_loader_ack,
  output logic [NUM_REQ-1:0]            m_load_received,
  output logic                          rom_loader_reset,
  output logic                          rom_loader_load,
  output logic [DATA_WIDTH-1:0]         rom_loader_data,
  input  logic                          rom_loader_ack,
  input  logic                          rom_loader_load_received,
  output logic                          cpu_reset_hold,
  output logic                          busy,
  output logic                          timeout
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

  arb_state_t              state_reg, state_next;
  logic [NUM_REQ-1:0]      grant_reg, grant_next;
  // One-hot round-robin pointer; bit 0 set means master 0 has top priority.
  logic [NUM_REQ-1:0]      rr_ptr_reg, rr_ptr_next;
  logic                    timeout_reg, timeout_next;
  logic [IDLE_W-1:0]       idle_cnt_reg, idle_cnt_next;
  logic [HOLD_W-1:0]       hold_cnt_reg, hold_cnt_next;
  logic                    ld_reset_reg, ld_reset_next;
  logic                    ld_load_reg, ld_load_next;
  logic [DATA_WIDTH-1:0]   ld_data_reg, ld_data_next;
  logic [NUM_REQ-1:0]      m_ack_reg, m_ack_next;
  logic [NUM_REQ-1:0]      m_lr_reg, m_lr_next;
  logic                    cpu_hold_reg, cpu_hold_next;
  logic                    busy_reg, busy_next;

  logic [NUM_REQ-1:0]      arb_grant;
  logic                    arb_valid;
  logic                    sel_reset, sel_load, sel_done, sel_req;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    idle_expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // AND-OR mux driven by the registered one-hot grant.
  assign sel_reset = |(grant_reg & m_rom_loader_reset);
  assign sel_load  = |(grant_reg & m_rom_loader_load);
  assign sel_done  = |(grant_reg & done);
  assign sel_req   = |(grant_reg & req);

  for (genvar gb = 0; gb < DATA_WIDTH; gb++) begin : g_data_bit
    logic [NUM_REQ-1:0] column;
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
      assign column[gi] = m_rom_loader_data[gi*DATA_WIDTH + gb];
    end
    assign sel_data[gb] = |(column & grant_reg);
  end

  assign idle_expired = (idle_cnt_reg == IDLE_LAST);

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    timeout_next  = timeout_reg;
    idle_cnt_next = '0;
    hold_cnt_next = (hold_cnt_reg != '0) ? hold_cnt_reg - HOLD_W'(1) : '0;
    ld_reset_next = 1'b0;
    ld_load_next  = 1'b0;
    ld_data_next  = '0;
    m_ack_next    = '0;
    m_lr_next     = '0;

    case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          state_next   = ST_GRANT;
          grant_next   = arb_grant;
          timeout_next = 1'b0;
        end
      end
      ST_GRANT: begin
        // Settle cycle: loader outputs stay at their zero defaults.
        state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (sel_done || !sel_req || idle_expired) begin
          // Loader outputs drop in the same edge that enters RELEASE.
          state_next    = ST_RELEASE;
          grant_next    = '0;
          rr_ptr_next   = {grant_reg[NUM_REQ-2:0], grant_reg[NUM_REQ-1]};
          hold_cnt_next = HOLD_INIT;
          if (idle_expired) begin
            timeout_next = 1'b1;
          end
        end else begin
          ld_reset_next = sel_reset;
          ld_load_next  = sel_load;
          ld_data_next  = sel_data;
          m_ack_next    = grant_reg & {NUM_REQ{rom_loader_ack}};
          m_lr_next     = grant_reg & {NUM_REQ{rom_loader_load_received}};
          if (rom_loader_load_received || ld_reset_reg) begin
            idle_cnt_next = '0;
          end else if (idle_cnt_reg != '1) begin
            idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
          end else begin
            idle_cnt_next = idle_cnt_reg;
          end
        end
      end
      ST_RELEASE: begin
        if (hold_cnt_reg == '0 && rom_loader_ack) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next     = (state_next != ST_IDLE);
    cpu_hold_next = (state_next != ST_IDLE) || (hold_cnt_next != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= NUM_REQ'(1);
      timeout_reg  <= 1'b0;
      idle_cnt_reg <= '0;
      hold_cnt_reg <= HOLD_INIT;
      ld_reset_reg <= 1'b0;
      ld_load_reg  <= 1'b0;
      ld_data_reg  <= '0;
      m_ack_reg    <= '0;
      m_lr_reg     <= '0;
      cpu_hold_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      timeout_reg  <= timeout_next;
      idle_cnt_reg <= idle_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      ld_reset_reg <= ld_reset_next;
      ld_load_reg  <= ld_load_next;
      ld_data_reg  <= ld_data_next;
      m_ack_reg    <= m_ack_next;
      m_lr_reg     <= m_lr_next;
      cpu_hold_reg <= cpu_hold_next;
      busy_reg     <= busy_next;
    end
  end

  assign grant            = grant_reg;
  assign m_rom_loader_ack = m_ack_reg;
  assign m_load_received  = m_lr_reg;
  assign rom_loader_reset = ld_reset_reg;
  assign rom_loader_load  = ld_load_reg;
  assign rom_loader_data  = ld_data_reg;
  assign cpu_reset_hold   = cpu_hold_reg;
  assign busy             = busy_reg;
  assign timeout          = timeout_reg;

endmodule
